// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one FIFO write port among
// NREQ producers and paces the FIFO read port for a single consumer. A shadow
// occupancy count prevents writes to a full FIFO and reads from an empty one.
module fifo_wr_arbiter #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 16,
    parameter int CNTW   = 5,
    parameter int AFULL  = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    output logic [NREQ-1:0]          gnt,
    input  logic                     rd_req,
    output logic                     rd_valid,
    output logic [DWIDTH-1:0]        rd_data,
    output logic [DWIDTH-1:0]        data_in,
    output logic                     signal_wr,
    output logic                     signal_oe,
    input  logic [DWIDTH-1:0]        data_out,
    output logic [CNTW-1:0]          level,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Registered state
    logic [NREQ-1:0]   gnt_reg;
    logic              signal_wr_reg;
    logic              signal_oe_reg;
    logic              oe_d_reg;       // pop issued last cycle; data_out valid now
    logic              rd_valid_reg;
    logic [DWIDTH-1:0] rd_data_reg;
    logic [DWIDTH-1:0] data_in_reg;
    logic [CNTW-1:0]   level_reg;
    logic [IW-1:0]     last_reg;       // index of the most recently granted requester

    // Next-state / combinational helpers
    logic [DWIDTH-1:0] req_word [NREQ];
    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   gnt_next;
    logic [CNTW:0]     cnext_wide;
    logic [CNTW-1:0]   cnext;
    logic              space;
    logic              pick_valid;
    logic [IW-1:0]     pick_idx;
    logic              do_write;
    logic              signal_oe_next;

    // Unpack the flat requester data bus into one word per requester
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_word[gi] = req_data[gi*DWIDTH +: DWIDTH];
        end
    endgenerate

    // Occupancy after the strobes currently on the FIFO pins commit at the next edge.
    // The extra top bit keeps level+1 representable regardless of CNTW headroom.
    assign cnext_wide = {1'b0, level_reg}
                      + {{CNTW{1'b0}}, signal_wr_reg}
                      - {{CNTW{1'b0}}, signal_oe_reg};
    assign cnext      = cnext_wide[CNTW-1:0];
    assign space      = (cnext_wide < (CNTW+1)'(DEPTH));

    // A requester holding a grant this cycle is replacing its word at this edge,
    // so it must not be picked again until it has had a chance to update.
    assign elig = req & ~gnt_reg;

    // Round-robin search: walk from the farthest slot back to last+1 so the
    // nearest eligible requester after last overwrites earlier hits.
    always_comb begin
        int pos;
        pos        = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            pos = (int'(last_reg) + k) % NREQ;
            if (elig[IW'(pos)]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'(pos);
            end
        end
    end

    assign do_write = pick_valid & space;

    // One-hot grant vector for the winning requester
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign gnt_next[gi] = do_write && (pick_idx == IW'(gi));
        end
    endgenerate

    // Pops are spaced at least two cycles apart and only against a non-empty count
    assign signal_oe_next = rd_req & (cnext_wide != '0) & ~signal_oe_reg;

    // Arbitration, FIFO strobes, read return pipeline and shadow occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_reg       <= '0;
            signal_wr_reg <= 1'b0;
            signal_oe_reg <= 1'b0;
            oe_d_reg      <= 1'b0;
            rd_valid_reg  <= 1'b0;
            rd_data_reg   <= '0;
            data_in_reg   <= '0;
            level_reg     <= '0;
            last_reg      <= IW'(NREQ - 1);
        end else begin
            level_reg     <= cnext;
            gnt_reg       <= gnt_next;
            signal_wr_reg <= do_write;
            if (do_write) begin
                data_in_reg <= req_word[pick_idx];
                last_reg    <= pick_idx;
            end
            signal_oe_reg <= signal_oe_next;
            oe_d_reg      <= signal_oe_reg;
            rd_valid_reg  <= oe_d_reg;
            if (oe_d_reg) begin
                rd_data_reg <= data_out;
            end
        end
    end

    assign gnt         = gnt_reg;
    assign signal_wr   = signal_wr_reg;
    assign signal_oe   = signal_oe_reg;
    assign data_in     = data_in_reg;
    assign rd_valid    = rd_valid_reg;
    assign rd_data     = rd_data_reg;
    assign level       = level_reg;
    assign full        = (level_reg == CNTW'(DEPTH));
    assign empty       = (level_reg == '0);
    assign almost_full = (level_reg >= CNTW'(AFULL));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: a small behavioural FIFO sits on the FIFO
// pins; a vector table covers reset, arbitration and single reads, and
// hand-written sequences cover single-requester pacing, fill/drain and
// reset mid-stream.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int CNTW  = 5;
    localparam int AFULL = 12;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      gnt;
    logic                 rd_req;
    logic                 rd_valid;
    logic [DW-1:0]        rd_data;
    logic [DW-1:0]        data_in;
    logic                 signal_wr;
    logic                 signal_oe;
    logic [DW-1:0]        data_out;
    logic [CNTW-1:0]      level;
    logic                 full;
    logic                 empty;
    logic                 almost_full;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NREQ(NREQ), .DWIDTH(DW), .DEPTH(DEPTH), .CNTW(CNTW), .AFULL(AFULL)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
        .data_in(data_in), .signal_wr(signal_wr), .signal_oe(signal_oe),
        .data_out(data_out), .level(level), .full(full), .empty(empty),
        .almost_full(almost_full)
    );

    // Behavioural FIFO on the DUT's FIFO pins, reset by the same rst
    logic [DW-1:0] fmem [DEPTH];
    logic [4:0]    fcnt;
    logic [3:0]    fwp, frp;
    logic          ovf_err = 1'b0;
    logic          udf_err = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            fcnt     <= '0;
            fwp      <= '0;
            frp      <= '0;
            data_out <= '0;
        end else begin
            if (signal_wr && fcnt == 5'(DEPTH)) ovf_err <= 1'b1;
            if (signal_oe && fcnt == 5'd0)      udf_err <= 1'b1;
            if (signal_wr) begin
                fmem[fwp] <= data_in;
                fwp       <= fwp + 4'd1;
            end
            if (signal_oe) begin
                data_out <= fmem[frp];
                frp      <= frp + 4'd1;
            end
            fcnt <= fcnt + 5'(signal_wr) - 5'(signal_oe);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; rd_req = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] word(input int i, input int k);
        return 32'((i << 8) | k);
    endfunction

    function automatic logic [31:0] tdata(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        rd;
        logic [3:0]  gnt;
        logic        wr;
        logic        oe;
        logic        rv;
        logic [4:0]  lvl;
        logic [31:0] rdat;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic rd,
                                input logic [3:0] g, input logic w, input logic o,
                                input logic v, input logic [4:0] l, input logic [31:0] d);
        vec_t t;
        t.rst = r; t.req = rq; t.rd = rd; t.gnt = g; t.wr = w;
        t.oe = o; t.rv = v; t.lvl = l; t.rdat = d;
        return t;
    endfunction

    vec_t tbl [24];
    int   cnt [NREQ];

    initial begin
        // rst req  rd   gnt    wr oe rv lvl  rdat
        tbl[0]  = mk(1, 4'h0, 0, 4'h0, 0, 0, 0, 5'd0, 0);
        tbl[1]  = mk(1, 4'h0, 0, 4'h0, 0, 0, 0, 5'd0, 0);
        tbl[2]  = mk(0, 4'h0, 0, 4'h0, 0, 0, 0, 5'd0, 0);
        tbl[3]  = mk(0, 4'hF, 0, 4'h1, 1, 0, 0, 5'd0, 0);
        tbl[4]  = mk(0, 4'hF, 0, 4'h2, 1, 0, 0, 5'd1, 0);
        tbl[5]  = mk(0, 4'hF, 0, 4'h4, 1, 0, 0, 5'd2, 0);
        tbl[6]  = mk(0, 4'hF, 0, 4'h8, 1, 0, 0, 5'd3, 0);
        tbl[7]  = mk(0, 4'hF, 0, 4'h1, 1, 0, 0, 5'd4, 0);
        tbl[8]  = mk(0, 4'h0, 0, 4'h0, 0, 0, 0, 5'd5, 0);
        tbl[9]  = mk(0, 4'h0, 1, 4'h0, 0, 1, 0, 5'd5, 0);
        tbl[10] = mk(0, 4'h0, 1, 4'h0, 0, 0, 0, 5'd4, 0);
        tbl[11] = mk(0, 4'h0, 0, 4'h0, 0, 0, 1, 5'd4, tdata(0));
        tbl[12] = mk(0, 4'h0, 0, 4'h0, 0, 0, 0, 5'd4, 0);
        tbl[13] = mk(0, 4'h4, 0, 4'h4, 1, 0, 0, 5'd4, 0);
        tbl[14] = mk(0, 4'h4, 0, 4'h0, 0, 0, 0, 5'd5, 0);
        tbl[15] = mk(0, 4'h4, 0, 4'h4, 1, 0, 0, 5'd5, 0);
        tbl[16] = mk(0, 4'h0, 0, 4'h0, 0, 0, 0, 5'd6, 0);
        tbl[17] = mk(0, 4'h9, 0, 4'h8, 1, 0, 0, 5'd6, 0);
        tbl[18] = mk(0, 4'h9, 0, 4'h1, 1, 0, 0, 5'd7, 0);
        tbl[19] = mk(0, 4'h0, 0, 4'h0, 0, 0, 0, 5'd8, 0);
        tbl[20] = mk(0, 4'hF, 1, 4'h2, 1, 1, 0, 5'd8, 0);
        tbl[21] = mk(0, 4'hF, 1, 4'h4, 1, 0, 0, 5'd8, 0);
        tbl[22] = mk(0, 4'h0, 0, 4'h0, 0, 0, 1, 5'd9, tdata(1));
        tbl[23] = mk(0, 4'h0, 0, 4'h0, 0, 0, 0, 5'd9, 0);

        rst = 1'b1; req = '0; rd_req = 1'b0;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = tdata(i);

        // ---------------- table-driven vectors ----------------
        for (int v = 0; v < 24; v++) begin
            rst = tbl[v].rst; req = tbl[v].req; rd_req = tbl[v].rd;
            step();
            chk($sformatf("tbl%0d.gnt", v), 32'(gnt), 32'(tbl[v].gnt));
            chk($sformatf("tbl%0d.wr", v), 32'(signal_wr), 32'(tbl[v].wr));
            chk($sformatf("tbl%0d.oe", v), 32'(signal_oe), 32'(tbl[v].oe));
            chk($sformatf("tbl%0d.rv", v), 32'(rd_valid), 32'(tbl[v].rv));
            chk($sformatf("tbl%0d.level", v), 32'(level), 32'(tbl[v].lvl));
            chk($sformatf("tbl%0d.empty", v), 32'(empty), 32'(tbl[v].lvl == 0));
            chk($sformatf("tbl%0d.full", v), 32'(full), 32'(tbl[v].lvl == 5'(DEPTH)));
            chk($sformatf("tbl%0d.afull", v), 32'(almost_full), 32'(tbl[v].lvl >= 5'(AFULL)));
            if (tbl[v].wr) begin
                for (int i = 0; i < NREQ; i++)
                    if (tbl[v].gnt[i]) chk($sformatf("tbl%0d.data_in", v), data_in, tdata(i));
            end
            if (tbl[v].rv) chk($sformatf("tbl%0d.rd_data", v), rd_data, tbl[v].rdat);
            $display("vec %0d: gnt=%b wr=%b oe=%b rv=%b level=%0d", v, gnt, signal_wr, signal_oe, rd_valid, level);
        end

        // ---------------- single requester, data advances on grant ----------------
        begin
            logic [3:0]  eg [6];
            logic [4:0]  el [6];
            int          c2;
            eg = '{4'h4, 4'h0, 4'h4, 4'h0, 4'h4, 4'h0};
            el = '{5'd0, 5'd1, 5'd1, 5'd2, 5'd2, 5'd3};
            do_reset();
            step();
            c2 = 0;
            req = 4'b0100;
            req_data[2*DW +: DW] = 32'hA0;
            for (int c = 0; c < 6; c++) begin
                step();
                chk($sformatf("single%0d.gnt", c), 32'(gnt), 32'(eg[c]));
                chk($sformatf("single%0d.level", c), 32'(level), 32'(el[c]));
                if (eg[c] != 4'h0) chk($sformatf("single%0d.data_in", c), data_in, 32'hA0 + 32'(c / 2));
                $display("single %0d: gnt=%b data_in=0x%0h level=%0d", c, gnt, data_in, level);
                if (gnt[2]) begin
                    c2++;
                    if (c2 == 3) req[2] = 1'b0;
                    else req_data[2*DW +: DW] = 32'hA0 + 32'(c2);
                end
            end
        end

        // ---------------- fill with 20 words, no reads ----------------
        begin
            int nwr, nrd, lvl_model, cyc;
            logic prev_oe;
            do_reset();
            step();
            for (int i = 0; i < NREQ; i++) begin
                cnt[i] = 0;
                req_data[i*DW +: DW] = word(i, 0);
            end
            req = 4'hF;
            nwr = 0; lvl_model = 0;
            for (int c = 0; c < 30; c++) begin
                step();
                chk("fill.level", 32'(level), 32'(lvl_model));
                chk("fill.full", 32'(full), 32'(lvl_model == DEPTH));
                chk("fill.afull", 32'(almost_full), 32'(lvl_model >= AFULL));
                chk("fill.empty", 32'(empty), 32'(lvl_model == 0));
                if (signal_wr) begin
                    chk("fill.gnt_order", 32'(gnt), 32'(1 << (nwr % NREQ)));
                    chk("fill.data_in", data_in, word(nwr % NREQ, nwr / NREQ));
                    $display("fill write %0d: gnt=%b data_in=0x%0h", nwr, gnt, data_in);
                    nwr++;
                    lvl_model++;
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (gnt[i]) begin
                        cnt[i]++;
                        if (cnt[i] == 5) req[i] = 1'b0;
                        else req_data[i*DW +: DW] = word(i, cnt[i]);
                    end
                end
            end
            chk("fill.writes", 32'(nwr), 32'(DEPTH));
            chk("fill.level_end", 32'(level), 32'(DEPTH));
            chk("fill.full_end", 32'(full), 1);
            chk("fill.gnt_end", 32'(gnt), 0);

            // ---------------- drain, writes resume as space frees ----------------
            rd_req = 1'b1;
            nrd = 0; cyc = 0; prev_oe = 1'b0;
            while (nrd < 20 && cyc < 200) begin
                step();
                cyc++;
                chk("drain.level_bound", 32'(level > 5'(DEPTH)), 0);
                if (signal_oe) chk("drain.oe_spacing", 32'(prev_oe), 0);
                prev_oe = signal_oe;
                if (signal_wr) begin
                    chk("drain.data_in", data_in, word(nwr % NREQ, nwr / NREQ));
                    nwr++;
                end
                if (rd_valid) begin
                    chk($sformatf("drain.rd_data%0d", nrd), rd_data, word(nrd % NREQ, nrd / NREQ));
                    $display("read %0d: rd_data=0x%0h level=%0d", nrd, rd_data, level);
                    nrd++;
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (gnt[i]) begin
                        cnt[i]++;
                        if (cnt[i] == 5) req[i] = 1'b0;
                        else req_data[i*DW +: DW] = word(i, cnt[i]);
                    end
                end
            end
            chk("drain.reads", 32'(nrd), 20);
            chk("drain.total_writes", 32'(nwr), 20);
            chk("drain.level_end", 32'(level), 0);
            chk("drain.empty_end", 32'(empty), 1);
            // Consumer keeps asking on an empty FIFO: no pop may be issued
            for (int c = 0; c < 10; c++) begin
                step();
                chk("empty_read.oe", 32'(signal_oe), 0);
                chk("empty_read.rv", 32'(rd_valid), 0);
            end
            rd_req = 1'b0;
        end

        // ---------------- reset mid-stream ----------------
        do_reset();
        step();
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = tdata(i);
        req = 4'hF; rd_req = 1'b1;
        step();
        chk("mid.gnt1", 32'(gnt), 32'h1);
        chk("mid.oe1", 32'(signal_oe), 0);
        step();
        chk("mid.gnt2", 32'(gnt), 32'h2);
        chk("mid.wr2", 32'(signal_wr), 1);
        chk("mid.oe2", 32'(signal_oe), 1);
        $display("mid: before reset gnt=%b wr=%b oe=%b", gnt, signal_wr, signal_oe);
        rst = 1'b1;
        step();
        chk("mid.rst_gnt", 32'(gnt), 0);
        chk("mid.rst_wr", 32'(signal_wr), 0);
        chk("mid.rst_oe", 32'(signal_oe), 0);
        chk("mid.rst_rv", 32'(rd_valid), 0);
        chk("mid.rst_level", 32'(level), 0);
        chk("mid.rst_empty", 32'(empty), 1);
        rst = 1'b0; rd_req = 1'b0;
        step();
        chk("mid.restart_gnt", 32'(gnt), 32'h1);
        chk("mid.restart_rv", 32'(rd_valid), 0);
        $display("mid: after reset gnt=%b level=%0d", gnt, level);
        req = '0;
        step(); step();

        chk("fifo.overflow", 32'(ovf_err), 0);
        chk("fifo.underflow", 32'(udf_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
